// File: rtl/definitions.sv
// rtl/definitions.sv - shared scalar/vector type aliases
package definitions;
  typedef logic        ulogic1;
  typedef logic [15:0] ulogic16;
  typedef logic [63:0] ulogic64;
endpackage

// File: rtl/seq_gen_drv_pkg.sv
// rtl/seq_gen_drv_pkg.sv - types and helpers shared by the sequence_gen driver
package seq_gen_drv_pkg;
  import definitions::*;

  localparam int CNT_W = 17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD1,
    ST_LOAD2,
    ST_WAIT,
    ST_RESP,
    ST_CLR
  } drv_state_t;

  typedef enum logic [1:0] {
    RSP_OK      = 2'b00,
    RSP_OVF     = 2'b01,
    RSP_ERR     = 2'b10,
    RSP_TIMEOUT = 2'b11
  } rsp_status_t;

  typedef struct packed {
    rsp_status_t      status;
    ulogic64          data;
    logic [CNT_W-1:0] cycles;
  } drv_rsp_t;

  // 17-bit sum so order=16'hFFFF plus slack never wraps
  function automatic logic [CNT_W-1:0] timeout_limit(input ulogic16 ord,
                                                     input logic [CNT_W-1:0] extra);
    return {1'b0, ord} + CNT_W'(2) + extra;
  endfunction
endpackage

// File: rtl/seq_gen_drv_timer.sv
// rtl/seq_gen_drv_timer.sv - latency counter with timeout compare
module seq_gen_drv_timer
  import seq_gen_drv_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [CNT_W-1:0]  limit,
  output logic [CNT_W-1:0]  count,
  output logic              expired
);

  // saturate rather than wrap so a stuck enable cannot re-arm a timeout
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count >= limit);

endmodule

// File: rtl/seq_gen_drv.sv
// rtl/seq_gen_drv.sv - command/response driver for the sequence_gen input protocol
module seq_gen_drv
  import seq_gen_drv_pkg::*;
#(
  parameter int TIMEOUT_EXTRA = 1,
  parameter bit CLEAR_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_mode,
  input  logic [15:0] cmd_order,
  input  logic [63:0] cmd_data,
  output logic        load,
  output logic        fibonacci,
  output logic        triangle,
  output logic        clear,
  output logic [15:0] order,
  output logic [63:0] data_in,
  input  logic        done,
  input  logic        overflow,
  input  logic        error,
  input  logic [63:0] data_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_status,
  output logic [63:0] rsp_data,
  output logic [16:0] rsp_cycles
);

  drv_state_t       state, state_nxt;
  drv_rsp_t         rsp_q, rsp_nxt;
  logic             mode_q;
  logic             cmd_fire, term;
  logic [CNT_W-1:0] count, limit;
  logic             expired;

  assign cmd_fire = cmd_valid && (state == ST_IDLE);
  assign limit    = timeout_limit(order, CNT_W'(TIMEOUT_EXTRA));

  seq_gen_drv_timer u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state == ST_IDLE),
    .enable  ((state == ST_LOAD1) || (state == ST_LOAD2) || (state == ST_WAIT)),
    .limit   (limit),
    .count   (count),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // sequence_gen outputs only matter in WAIT; error > overflow > done > timeout
  always_comb begin
    term    = 1'b0;
    rsp_nxt = rsp_q;
    if (state == ST_WAIT) begin
      term           = error || overflow || done || expired;
      rsp_nxt.cycles = count;
      if (error) begin
        rsp_nxt.status = RSP_ERR;
        rsp_nxt.data   = data_out;
      end else if (overflow) begin
        rsp_nxt.status = RSP_OVF;
        rsp_nxt.data   = data_out;
      end else if (done) begin
        rsp_nxt.status = RSP_OK;
        rsp_nxt.data   = data_out;
      end else begin
        rsp_nxt.status = RSP_TIMEOUT;
        rsp_nxt.data   = '0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cmd_fire) state_nxt = ST_LOAD1;
      ST_LOAD1: state_nxt = ST_LOAD2;
      ST_LOAD2: state_nxt = ST_WAIT;
      ST_WAIT:  if (term) state_nxt = ST_RESP;
      ST_RESP:  if (rsp_ready) state_nxt = CLEAR_EN ? ST_CLR : ST_IDLE;
      ST_CLR:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    load      = 1'b0;
    fibonacci = 1'b0;
    triangle  = 1'b0;
    clear     = 1'b0;
    rsp_valid = 1'b0;
    cmd_ready = 1'b0;
    case (state)
      ST_IDLE:  cmd_ready = reset_n;
      ST_LOAD1, ST_LOAD2: begin
        load      = 1'b1;
        fibonacci = !mode_q;
        triangle  = mode_q;
      end
      ST_RESP:  rsp_valid = 1'b1;
      ST_CLR:   clear = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q  <= 1'b0;
      order   <= '0;
      data_in <= '0;
      rsp_q   <= '0;
    end else begin
      if (cmd_fire) begin
        mode_q  <= cmd_mode;
        order   <= cmd_order;
        data_in <= cmd_data;
      end
      if (term) begin
        rsp_q <= rsp_nxt;
      end
    end
  end

  assign rsp_status = rsp_q.status;
  assign rsp_data   = rsp_q.data;
  assign rsp_cycles = rsp_q.cycles;

endmodule

// File: tb/tb_seq_gen_drv.sv
// tb/tb_seq_gen_drv.sv - self-checking bench for seq_gen_drv
module tb_seq_gen_drv;

  localparam int EXTRA = 1;

  logic        clk = 1'b0;
  logic        reset_n, cmd_valid, cmd_mode, rsp_ready;
  logic [15:0] cmd_order;
  logic [63:0] cmd_data, data_out;
  logic        done, overflow, error;
  logic        cmd_ready, load, fibonacci, triangle, clear, rsp_valid;
  logic [15:0] order;
  logic [63:0] data_in, rsp_data;
  logic [1:0]  rsp_status;
  logic [16:0] rsp_cycles;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_gen_drv #(.TIMEOUT_EXTRA(EXTRA), .CLEAR_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_order(cmd_order), .cmd_data(cmd_data),
    .load(load), .fibonacci(fibonacci), .triangle(triangle), .clear(clear),
    .order(order), .data_in(data_in),
    .done(done), .overflow(overflow), .error(error), .data_out(data_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_data(rsp_data), .rsp_cycles(rsp_cycles)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fib_val(input int n, input logic [63:0] d);
    logic [63:0] a, b, t;
    a = d;
    b = d;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic logic [63:0] tri_val(input int n, input logic [63:0] d);
    return d * 64'(n) * 64'(n + 1) / 64'd2;
  endfunction

  // ev = {error, overflow, done} asserted at counter value ev_at
  task automatic run_cmd(input logic mode, input logic [15:0] ord, input logic [63:0] d,
                         input int ev_at, input logic [2:0] ev, input logic [63:0] dout,
                         input int bp, input bit spurious);
    int          limit, exp_cyc, cyc;
    logic [1:0]  exp_st;
    logic [63:0] exp_d;
    limit = int'(ord) + 2 + EXTRA;
    if (ev != 3'b000 && ev_at <= limit) begin
      exp_cyc = ev_at;
      exp_d   = dout;
      exp_st  = ev[2] ? 2'b10 : (ev[1] ? 2'b01 : 2'b00);
    end else begin
      exp_cyc = limit;
      exp_d   = '0;
      exp_st  = 2'b11;
    end

    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_order = ord;
    cmd_data  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_order = 16'($urandom);
    cmd_data  = {$urandom, $urandom};
    cyc = 0;
    while (!rsp_valid && cyc < limit + 10) begin
      if (cyc < 3) begin
        chk("load", load, cyc < 2);
        chk("fibonacci", fibonacci, (cyc < 2) && !mode);
        chk("triangle", triangle, (cyc < 2) && mode);
      end
      if (cyc == 1) begin
        chk("order", order, ord);
        chk("data_in", data_in, d);
        chk("cmd_ready_busy", cmd_ready, 0);
      end
      if (cyc == ev_at) begin
        {error, overflow, done} = ev;
        data_out = dout;
      end else begin
        {error, overflow, done} = (spurious && cyc < 2) ? 3'b111 : 3'b000;
        data_out = {$urandom, $urandom};
      end
      @(negedge clk);
      cyc++;
    end
    {error, overflow, done} = 3'b000;
    chk("rsp_valid", rsp_valid, 1);
    if (!rsp_valid) return;
    chk("rsp_latency", cyc, exp_cyc + 1);
    chk("rsp_status", rsp_status, exp_st);
    chk("rsp_data", rsp_data, exp_d);
    chk("rsp_cycles", rsp_cycles, exp_cyc);

    for (int i = 0; i < bp; i++) begin
      rsp_ready = 1'b0;
      data_out  = {$urandom, $urandom};
      {error, overflow, done} = 3'($urandom);
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_status", rsp_status, exp_st);
      chk("bp_data", rsp_data, exp_d);
      chk("bp_cycles", rsp_cycles, exp_cyc);
      chk("bp_cmd_ready", cmd_ready, 0);
    end
    {error, overflow, done} = 3'b000;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("clr_pulse", clear, 1);
    chk("clr_rsp_valid", rsp_valid, 0);
    chk("clr_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    chk("clr_end", clear, 0);
    chk("order_hold", order, ord);
  endtask

  initial begin
    logic [2:0] kinds [8];
    logic [2:0] kind;
    logic [15:0] ord;
    logic        mode;
    int          seen;
    kinds = '{3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111, 3'b000};

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode  = 1'b0;
    cmd_order = '0;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    {error, overflow, done} = 3'b000;
    data_out  = '0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_outs", {load, fibonacci, triangle, clear, rsp_valid}, 0);
    chk("rst_vals", {order, data_in, rsp_status, rsp_data, rsp_cycles}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);

    run_cmd(1'b0, 16'd10, 64'd1, 12, 3'b001, fib_val(10, 64'd1), 0, 1'b0);
    run_cmd(1'b1, 16'd4, 64'd1, 6, 3'b001, tri_val(4, 64'd1), 0, 1'b0);
    run_cmd(1'b0, 16'd90, 64'd1, 5, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);
    run_cmd(1'b0, 16'd7, 64'd3, 4, 3'b101, 64'h1234_5678_9ABC_DEF0, 0, 1'b1);
    run_cmd(1'b0, 16'd5, 64'd1, 99, 3'b000, 64'd0, 0, 1'b0);
    run_cmd(1'b1, 16'd3, 64'd2, 5, 3'b001, tri_val(3, 64'd2), 3, 1'b0);
    run_cmd(1'b0, 16'd6, 64'd1, 9, 3'b001, fib_val(6, 64'd1), 0, 1'b0);
    run_cmd(1'b1, 16'd0, 64'd5, 2, 3'b001, tri_val(0, 64'd5), 1, 1'b1);

    for (int n = 0; n < 12; n++) begin
      mode = 1'($urandom);
      ord  = 16'($urandom_range(0, 20));
      kind = kinds[$urandom_range(0, 7)];
      run_cmd(mode, ord, 64'($urandom_range(1, 9)), $urandom_range(2, int'(ord) + 4),
              kind, {$urandom, $urandom}, $urandom_range(0, 2), 1'($urandom));
    end

    cmd_valid = 1'b1;
    cmd_mode  = 1'b1;
    cmd_order = 16'd20;
    cmd_data  = 64'd7;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    chk("mid_rst_outs", {load, fibonacci, triangle, clear, rsp_valid}, 0);
    chk("mid_rst_vals", {order, data_in, rsp_status, rsp_data, rsp_cycles}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      {error, overflow, done} = 3'b111;
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    {error, overflow, done} = 3'b000;
    chk("no_rsp_after_rst", seen, 0);
    run_cmd(1'b0, 16'd10, 64'd1, 12, 3'b001, fib_val(10, 64'd1), 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
